// File: rtl/gas_pump_pkg.sv
// Shared types and widths for the gas pump dispensing path.
// Holds the FSM state and stop-reason encodings plus the credit-limit compare.
package gas_pump_pkg;

  localparam int PRICE_W = 8;
  localparam int COST_W  = 16;
  localparam int LITER_W = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CHECK    = 2'd1,
    DISPENSE = 2'd2,
    FINISH   = 2'd3
  } disp_state_t;

  typedef enum logic [1:0] {
    FULL    = 2'd0,
    CREDIT  = 2'd1,
    TIMEOUT = 2'd2,
    ABORT   = 2'd3
  } stop_reason_t;

  // True when one more litre at this price would push the charge past the credit.
  // Done at COST_W+1 bits so cost+price can never wrap.
  function automatic logic credit_exceeded(input logic [COST_W-1:0]  cost,
                                           input logic [PRICE_W-1:0] price,
                                           input logic [PRICE_W-1:0] credit);
    logic [COST_W:0] next_cost;
    logic [COST_W:0] limit;
    next_cost = {1'b0, cost} + {{(COST_W + 1 - PRICE_W){1'b0}}, price};
    limit     = {{(COST_W + 1 - PRICE_W){1'b0}}, credit};
    return next_cost > limit;
  endfunction

endpackage

// File: rtl/flow_meter_counter.sv
// Flow-meter prescaler (pulses -> whole litres) and stall watchdog.
// Counting happens only while enabled; clear wins over everything.
module flow_meter_counter #(
  parameter int unsigned PULSES_PER_LITER = 10,
  parameter int unsigned TIMEOUT_CYCLES   = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic flow_pulse,
  output logic liter_tick,
  output logic stall
);

  localparam int PCNT_W = $clog2(PULSES_PER_LITER);
  localparam int TCNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PULSES_PER_LITER - 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

  logic [PCNT_W-1:0] pulse_cnt_q, pulse_cnt_d;
  logic [TCNT_W-1:0] tout_cnt_q, tout_cnt_d;
  logic              pulse_last;
  logic              tout_last;

  assign pulse_last = (pulse_cnt_q == PCNT_LAST);
  assign tout_last  = (tout_cnt_q == TCNT_LAST);
  assign liter_tick = enable & flow_pulse & pulse_last;
  assign stall      = enable & ~flow_pulse & tout_last;

  // NOTE: every variable gets its hold value first, so no branch can leave one unassigned and infer a latch.
  always_comb begin
    pulse_cnt_d = pulse_cnt_q;
    tout_cnt_d  = tout_cnt_q;
    if (clear) begin
      pulse_cnt_d = '0;
      tout_cnt_d  = '0;
    end else if (enable) begin
      if (flow_pulse) begin
        tout_cnt_d  = '0;
        pulse_cnt_d = pulse_last ? '0 : pulse_cnt_q + PCNT_W'(1);
      end else if (!tout_last) begin
        tout_cnt_d = tout_cnt_q + TCNT_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pulse_cnt_q <= '0;
      tout_cnt_q  <= '0;
    end else begin
      pulse_cnt_q <= pulse_cnt_d;
      tout_cnt_q  <= tout_cnt_d;
    end
  end

endmodule

// File: rtl/gas_dispense_controller.sv
// Closed-loop fuel delivery: opens the valve, counts litres and charge, and stops
// on full tank, credit limit, flow stall or customer abort with a one-cycle done.
module gas_dispense_controller
  import gas_pump_pkg::*;
#(
  parameter int unsigned PULSES_PER_LITER = 10,
  parameter int unsigned TIMEOUT_CYCLES   = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [LITER_W-1:0] fuel_to_add,
  input  logic [PRICE_W-1:0] price_per_liter,
  input  logic [PRICE_W-1:0] customer_credit,
  input  logic               flow_pulse,
  output logic               valve_open,
  output logic               busy,
  output logic [LITER_W-1:0] liters_dispensed,
  output logic [COST_W-1:0]  amount_charged,
  output logic [1:0]         stop_reason,
  output logic               done
);

  disp_state_t        state_q, state_d;
  stop_reason_t       reason_q, reason_d;
  logic [LITER_W-1:0] target_q, target_d;
  logic [PRICE_W-1:0] price_q, price_d;
  logic [PRICE_W-1:0] credit_q, credit_d;
  logic [LITER_W-1:0] liters_q, liters_d;
  logic [COST_W-1:0]  charge_q, charge_d;
  logic               valve_q, valve_d;

  logic counter_clear;
  logic counter_enable;
  logic liter_tick;
  logic stall;

  assign counter_clear  = (state_q == IDLE) && start;
  assign counter_enable = (state_q == DISPENSE);

  flow_meter_counter #(
    .PULSES_PER_LITER (PULSES_PER_LITER),
    .TIMEOUT_CYCLES   (TIMEOUT_CYCLES)
  ) u_flow_meter (
    .clk        (clk),
    .reset      (reset),
    .clear      (counter_clear),
    .enable     (counter_enable),
    .flow_pulse (flow_pulse),
    .liter_tick (liter_tick),
    .stall      (stall)
  );

  always_comb begin
    state_d  = state_q;
    reason_d = reason_q;
    target_d = target_q;
    price_d  = price_q;
    credit_d = credit_q;
    liters_d = liters_q;
    charge_d = charge_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          target_d = fuel_to_add;
          price_d  = price_per_liter;
          credit_d = customer_credit;
          liters_d = '0;
          charge_d = '0;
          state_d  = CHECK;
        end
      end

      CHECK: begin
        if (target_q == '0) begin
          reason_d = FULL;
          state_d  = FINISH;
        end else if (price_q > credit_q) begin
          reason_d = CREDIT;
          state_d  = FINISH;
        end else begin
          state_d = DISPENSE;
        end
      end

      DISPENSE: begin
        // Abort outranks a coincident pulse, so a partial litre is never billed.
        if (abort) begin
          reason_d = ABORT;
          state_d  = FINISH;
        end else if (liter_tick) begin
          liters_d = liters_q + LITER_W'(1);
          charge_d = charge_q + COST_W'(price_q);
          if (liters_d == target_q) begin
            reason_d = FULL;
            state_d  = FINISH;
          end else if (credit_exceeded(charge_d, price_q, credit_q)) begin
            reason_d = CREDIT;
            state_d  = FINISH;
          end
        end else if (stall) begin
          reason_d = TIMEOUT;
          state_d  = FINISH;
        end
      end

      FINISH: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    valve_d = (state_d == DISPENSE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      reason_q <= FULL;
      target_q <= '0;
      price_q  <= '0;
      credit_q <= '0;
      liters_q <= '0;
      charge_q <= '0;
      valve_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      reason_q <= reason_d;
      target_q <= target_d;
      price_q  <= price_d;
      credit_q <= credit_d;
      liters_q <= liters_d;
      charge_q <= charge_d;
      valve_q  <= valve_d;
    end
  end

  assign valve_open       = valve_q;
  assign busy             = (state_q != IDLE);
  assign done             = (state_q == FINISH);
  assign liters_dispensed = liters_q;
  assign amount_charged   = charge_q;
  assign stop_reason      = reason_q;

endmodule

// File: tb/tb_gas_dispense_controller.sv
// Self-checking bench: directed and random sessions compared against an outcome
// model built from pulse counts, prices and the stall window.
module tb_gas_dispense_controller;

  localparam int PPL  = 10;
  localparam int TOUT = 20;
  localparam int MAXK = 512;
  localparam int PULSE_LIMIT = 400;

  localparam int R_FULL    = 0;
  localparam int R_CREDIT  = 1;
  localparam int R_TIMEOUT = 2;
  localparam int R_ABORT   = 3;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [7:0]  fuel_to_add;
  logic [7:0]  price_per_liter;
  logic [7:0]  customer_credit;
  logic        flow_pulse;
  logic        valve_open;
  logic        busy;
  logic [7:0]  liters_dispensed;
  logic [15:0] amount_charged;
  logic [1:0]  stop_reason;
  logic        done;

  int checks = 0;
  int errors = 0;

  // Pulse schedule indexed by DISPENSE cycle (0 = first cycle the valve is open).
  bit sched [MAXK];
  int abort_at;

  gas_dispense_controller #(
    .PULSES_PER_LITER (PPL),
    .TIMEOUT_CYCLES   (TOUT)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .abort            (abort),
    .fuel_to_add      (fuel_to_add),
    .price_per_liter  (price_per_liter),
    .customer_credit  (customer_credit),
    .flow_pulse       (flow_pulse),
    .valve_open       (valve_open),
    .busy             (busy),
    .liters_dispensed (liters_dispensed),
    .amount_charged   (amount_charged),
    .stop_reason      (stop_reason),
    .done             (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_sched();
    for (int k = 0; k < MAXK; k++) sched[k] = 1'b0;
    abort_at = -1;
  endtask

  // Outcome of a session from the rules: early exits, then walk the schedule
  // tracking pulses delivered and the last pulse time for the stall window.
  task automatic model(input int tgt, input int prc, input int crd,
                       output int k_stop, output int liters, output int reason);
    int pulses;
    int last;
    int l;
    k_stop = -1;
    liters = 0;
    reason = R_FULL;
    if (tgt == 0) begin
      reason = R_FULL;
      return;
    end
    if (prc > crd) begin
      reason = R_CREDIT;
      return;
    end
    pulses = 0;
    last   = -1;
    for (int k = 0; k < MAXK; k++) begin
      if (k == abort_at) begin
        k_stop = k; liters = pulses / PPL; reason = R_ABORT;
        return;
      end
      if (sched[k]) begin
        pulses++;
        last = k;
        if (pulses % PPL == 0) begin
          l = pulses / PPL;
          if (l == tgt) begin
            k_stop = k; liters = l; reason = R_FULL;
            return;
          end
          if ((l + 1) * prc > crd) begin
            k_stop = k; liters = l; reason = R_CREDIT;
            return;
          end
        end
      end else if (k == last + TOUT) begin
        k_stop = k; liters = pulses / PPL; reason = R_TIMEOUT;
        return;
      end
    end
    k_stop = MAXK - 1;
    liters = pulses / PPL;
    reason = R_TIMEOUT;
  endtask

  task automatic run_session(input string name, input int tgt, input int prc,
                             input int crd, input int glitch_at);
    int k_stop, exp_l, exp_r, pulses;
    model(tgt, prc, crd, k_stop, exp_l, exp_r);

    fuel_to_add     = 8'(tgt);
    price_per_liter = 8'(prc);
    customer_credit = 8'(crd);
    start = 1'b1;
    tick();
    start = 1'b0;
    fuel_to_add     = 8'($urandom);
    price_per_liter = 8'($urandom);
    customer_credit = 8'($urandom);
    check({name, " busy_in_check"}, busy, 1);
    check({name, " valve_in_check"}, valve_open, 0);
    check({name, " liters_cleared"}, liters_dispensed, 0);
    check({name, " charge_cleared"}, amount_charged, 0);

    flow_pulse = 1'($urandom);
    tick();
    flow_pulse = 1'b0;

    if (k_stop < 0) begin
      check({name, " early_done"}, done, 1);
      check({name, " early_valve"}, valve_open, 0);
      check({name, " early_liters"}, liters_dispensed, 0);
      check({name, " early_reason"}, stop_reason, exp_r);
    end else begin
      check({name, " valve_opened"}, valve_open, 1);
      check({name, " no_early_done"}, done, 0);
      pulses = 0;
      for (int k = 0; k <= k_stop; k++) begin
        flow_pulse = sched[k];
        abort      = (k == abort_at);
        start      = (k == glitch_at);
        if (start) begin
          fuel_to_add     = 8'($urandom_range(1, 255));
          price_per_liter = 8'($urandom);
          customer_credit = 8'($urandom);
        end
        tick();
        flow_pulse = 1'b0;
        abort      = 1'b0;
        start      = 1'b0;
        if (k < k_stop) begin
          if (sched[k]) pulses++;
          check({name, " run_done"}, done, 0);
          check({name, " run_valve"}, valve_open, 1);
          check({name, " run_liters"}, liters_dispensed, pulses / PPL);
        end else begin
          check({name, " stop_done"}, done, 1);
          check({name, " stop_valve"}, valve_open, 0);
          check({name, " stop_busy"}, busy, 1);
          check({name, " stop_liters"}, liters_dispensed, exp_l);
          check({name, " stop_charge"}, amount_charged, exp_l * prc);
          check({name, " stop_reason"}, stop_reason, exp_r);
        end
      end
    end

    tick();
    check({name, " done_one_cycle"}, done, 0);
    check({name, " idle_busy"}, busy, 0);
    for (int i = 0; i < 4; i++) begin
      flow_pulse = 1'($urandom);
      abort      = 1'($urandom);
      tick();
    end
    flow_pulse = 1'b0;
    abort      = 1'b0;
    check({name, " hold_liters"}, liters_dispensed, exp_l);
    check({name, " hold_charge"}, amount_charged, exp_l * prc);
    check({name, " hold_reason"}, stop_reason, exp_r);
    check({name, " hold_valve"}, valve_open, 0);
    check({name, " hold_done"}, done, 0);
  endtask

  initial begin
    int tgt, prc, crd, p;
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    flow_pulse = 1'b0;
    fuel_to_add = '0;
    price_per_liter = '0;
    customer_credit = '0;
    tick();
    tick();
    check("reset_valve", valve_open, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_liters", liters_dispensed, 0);
    check("reset_charge", amount_charged, 0);
    check("reset_reason", stop_reason, R_FULL);
    reset = 1'b0;
    tick();

    // Normal fill, with a start request mid-dispense that must be ignored.
    clear_sched();
    for (int i = 0; i < 30; i++) sched[3 * i + 2] = 1'b1;
    run_session("fill", 3, 5, 100, 40);

    // Credit limit reached after two litres.
    clear_sched();
    for (int i = 0; i < 60; i++) sched[2 * i] = 1'b1;
    run_session("credit", 10, 20, 50, -1);

    clear_sched();
    run_session("early_credit", 5, 30, 20, -1);
    clear_sched();
    run_session("early_full", 0, 10, 100, -1);

    // Abort coincident with the eighth pulse: nothing charged.
    clear_sched();
    for (int i = 0; i < 8; i++) sched[2 * i] = 1'b1;
    abort_at = 14;
    run_session("abort", 4, 9, 200, -1);

    // One litre, then silence until the stall watchdog fires.
    clear_sched();
    for (int k = 1; k <= 10; k++) sched[k] = 1'b1;
    run_session("stall", 5, 7, 200, -1);

    // Reset in the middle of dispensing discards the session.
    clear_sched();
    fuel_to_add = 8'd5; price_per_liter = 8'd1; customer_credit = 8'd255;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int k = 0; k < 15; k++) begin
      flow_pulse = 1'b1;
      tick();
    end
    flow_pulse = 1'b0;
    check("pre_reset_valve", valve_open, 1);
    check("pre_reset_liters", liters_dispensed, 1);
    #3;
    reset = 1'b1;
    #1;
    check("async_valve", valve_open, 0);
    check("async_busy", busy, 0);
    check("async_done", done, 0);
    check("async_liters", liters_dispensed, 0);
    check("async_charge", amount_charged, 0);
    check("async_reason", stop_reason, R_FULL);
    tick();
    tick();
    check("reset_hold_done", done, 0);
    reset = 1'b0;
    tick();

    clear_sched();
    for (int i = 0; i < 20; i++) sched[i] = 1'b1;
    run_session("after_reset", 2, 11, 200, -1);

    // Random sessions.
    for (int s = 0; s < 12; s++) begin
      clear_sched();
      tgt = $urandom_range(0, 6);
      prc = $urandom_range(0, 60);
      crd = $urandom_range(0, 255);
      p   = $urandom_range(30, 95);
      for (int k = 0; k < PULSE_LIMIT; k++) sched[k] = ($urandom_range(0, 99) < p);
      if ($urandom_range(0, 3) == 0) abort_at = $urandom_range(0, 150);
      run_session($sformatf("rand%0d", s), tgt, prc, crd,
                  ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 60)) : -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
